// File: rtl/iter_hspan.sv
// Multi-lane horizontal span iterator: walks min(x0,x1)..max(x0,x1), LANES pixels per accepted cycle.
// Optional clipping to column XMAX is compiled in when ITER_HSPAN_CLIP_EN is defined.
module iter_hspan #(
    parameter int CORDW = 10,
    parameter int LANES = 4,
    parameter int XMAX  = 639
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             oe,
    input  logic [CORDW-1:0] x0,
    input  logic [CORDW-1:0] x1,
    input  logic [CORDW-1:0] y,
    output logic [CORDW-1:0] x,
    output logic [CORDW-1:0] y_out,
    output logic [LANES-1:0] mask,
    output logic             drawing,
    output logic             busy,
    output logic             done
);

`ifdef ITER_HSPAN_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    localparam logic [CORDW:0]   LANES_W = (CORDW+1)'(LANES);
    localparam logic [CORDW-1:0] STEP    = CORDW'(LANES);
    localparam logic [CORDW:0]   XMAX_W  = (CORDW+1)'(XMAX);

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t           state_reg, state_next;
    logic [CORDW-1:0] x_reg, x_next;
    logic [CORDW-1:0] y_reg, y_next;
    logic [CORDW-1:0] hi_reg, hi_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic [CORDW-1:0] lo, hi_in;
    logic [CORDW:0]   remain;
    logic             last_group;

    assign lo    = (x0 < x1) ? x0 : x1;
    assign hi_in = (x0 < x1) ? x1 : x0;

    // Distance to hi in one extra bit so the comparison stays valid up to 2^CORDW-1.
    assign remain     = {1'b0, hi_reg} - {1'b0, x_reg};
    assign last_group = (remain < LANES_W);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [CORDW:0] lane_x;
            assign lane_x   = {1'b0, x_reg} + (CORDW+1)'(gi);
            assign mask[gi] = (state_reg == DRAW) && (lane_x <= {1'b0, hi_reg});
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        hi_next    = hi_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    x_next    = lo;
                    y_next    = y;
                    busy_next = 1'b1;
                    if (CLIP_ON && ({1'b0, lo} > XMAX_W)) begin
                        state_next = FIN;
                    end else begin
                        state_next = DRAW;
                        if (CLIP_ON && ({1'b0, hi_in} > XMAX_W))
                            hi_next = XMAX_W[CORDW-1:0];
                        else
                            hi_next = hi_in;
                    end
                end
            end
            DRAW: begin
                if (oe) begin
                    if (last_group) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        x_next = x_reg + STEP;
                    end
                end
            end
            FIN: begin
                // Span clipped away entirely: finish without any drawing cycle.
                state_next = IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            hi_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            hi_reg    <= hi_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign x       = x_reg;
    assign y_out   = y_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign drawing = (state_reg == DRAW) && oe;

endmodule

// File: tb/tb_iter_hspan.sv
// Self-checking bench for iter_hspan: directed and random spans against a group-list reference model.
module tb_iter_hspan;
    localparam int CORDW = 10;
    localparam int LANES = 4;
    localparam int XMAX  = 639;

    logic             clk = 1'b0;
    logic             rst, start, oe;
    logic [CORDW-1:0] x0, x1, y;
    logic [CORDW-1:0] x, y_out;
    logic [LANES-1:0] mask;
    logic             drawing, busy, done;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        int gx;
        int gmask;
    } grp_t;

    grp_t q[$];

    iter_hspan #(.CORDW(CORDW), .LANES(LANES), .XMAX(XMAX)) dut (
        .clk(clk), .rst(rst), .start(start), .oe(oe),
        .x0(x0), .x1(x1), .y(y),
        .x(x), .y_out(y_out), .mask(mask),
        .drawing(drawing), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list every group the span must produce, from the endpoint rules alone.
    task automatic build_model(input int a, input int b);
        int lo, hi, m;
        q.delete();
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
`ifdef ITER_HSPAN_CLIP_EN
        if (lo > XMAX) return;
        if (hi > XMAX) hi = XMAX;
`endif
        for (int g = lo; g <= hi; g += LANES) begin
            m = 0;
            for (int i = 0; i < LANES; i++)
                if (g + i <= hi) m |= (1 << i);
            q.push_back('{gx: g, gmask: m});
        end
    endtask

    // Entered and left at a falling edge (+1 after the done check).
    task automatic run_span(input int a, input int b, input int yv, input bit rand_oe, input bit poke);
        int cyc;
        int ngrp;
        build_model(a, b);
        ngrp = q.size();
        start = 1'b1; x0 = CORDW'(a); x1 = CORDW'(b); y = CORDW'(yv);
        @(negedge clk);
        start = 1'b0; x0 = CORDW'($urandom); x1 = CORDW'($urandom); y = CORDW'($urandom);
        if (ngrp == 0) begin
            #1;
            chk("fin_busy", 32'(busy), 1);
            chk("fin_drawing", 32'(drawing), 0);
            @(negedge clk);
        end
        cyc = 0;
        while (q.size() > 0 && cyc < 4000) begin
            oe    = rand_oe ? 1'($urandom_range(0, 1)) : 1'b1;
            start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            x0 = CORDW'($urandom); x1 = CORDW'($urandom);
            #1;
            chk("busy", 32'(busy), 1);
            chk("done_low", 32'(done), 0);
            chk("drawing", 32'(drawing), 32'(oe));
            chk("y_out", 32'(y_out), 32'(yv));
            chk("x", 32'(x), 32'(q[0].gx));
            chk("mask", 32'(mask), 32'(q[0].gmask));
            $display("span %0d..%0d x=%0d mask=%b oe=%0d", a, b, x, mask, oe);
            if (oe) void'(q.pop_front());
            @(negedge clk);
            cyc++;
        end
        chk("budget", 32'(q.size()), 0);
        start = 1'b0;
        oe    = 1'($urandom_range(0, 1));
        #1;
        chk("done_pulse", 32'(done), 1);
        chk("busy_end", 32'(busy), 0);
        chk("drawing_end", 32'(drawing), 0);
        chk("mask_end", 32'(mask), 0);
        $display("span %0d..%0d complete, %0d groups", a, b, ngrp);
    endtask

    initial begin
        int a, b;
        rst = 1'b1; start = 1'b0; oe = 1'b0; x0 = '0; x1 = '0; y = '0;
        repeat (3) @(negedge clk);
        oe = 1'b1;
        #1;
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y_out), 0);
        chk("rst_mask", 32'(mask), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_drawing", 32'(drawing), 0);
        @(negedge clk);
        rst = 1'b0;

        run_span(10, 17, 3, 1'b0, 1'b0);
        run_span(20, 13, 4, 1'b0, 1'b0);   // back-to-back: start lands in the done cycle
        run_span(13, 20, 4, 1'b0, 1'b0);
        run_span(5, 5, 7, 1'b1, 1'b0);
        run_span(100, 140, 9, 1'b1, 1'b1);
        run_span(1020, 1023, 11, 1'b0, 1'b0);
        run_span(1023, 1023, 12, 1'b1, 1'b0);
        run_span(0, 1023, 13, 1'b0, 1'b1);
`ifdef ITER_HSPAN_CLIP_EN
        run_span(630, 700, 14, 1'b0, 1'b0);
        run_span(650, 700, 15, 1'b0, 1'b0);
`endif

        // Reset on the second drawing cycle aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; x0 = 10'd0; x1 = 10'd100; y = 10'd21; oe = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_mask", 32'(mask), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_drawing", 32'(drawing), 0);
        @(negedge clk);
        #1;
        chk("abort_no_done", 32'(done), 0);
        $display("reset mid-span checked");
        @(negedge clk);

        for (int n = 0; n < 25; n++) begin
            a = $urandom_range(0, 1023);
            b = (n % 3 == 0) ? $urandom_range(0, 1023) : a + $urandom_range(0, 40) - 20;
            if (b < 0) b = 0;
            if (b > 1023) b = 1023;
            run_span(a, b, $urandom_range(0, 1023), 1'b1, 1'b1);
            if ($urandom_range(0, 1)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
